// File: rtl/aurora_link_supervisor.sv
// Closed-loop Aurora reset sequencer: drives PMA init / reset_pb, qualifies link-up,
// and retrains on loss or timeout, escalating from reset_pb-only retries to full PMA init.

module aurora_link_supervisor #(
    parameter int unsigned PmaInitCycles     = 75_000_000,
    parameter int unsigned ResetPbCycles     = 25_000_000,
    parameter int unsigned LinkTimeoutCycles = 100_000_000,
    parameter int unsigned StableCycles      = 50_000_000,
    parameter int unsigned MaxSoftRetries    = 3,
    parameter int unsigned CntWidth          = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       aurora_gt_pll_lock,
    input  logic       aurora_channel_up,
    input  logic       aurora_lane_up,
    input  logic       relink_req,
    output logic       aurora_pma_init,
    output logic       aurora_reset_pb,
    output logic       peri_reset,
    output logic       link_ok,
    output logic [7:0] retry_count,
    output logic [2:0] link_state
);

    typedef enum logic [2:0] {
        PMA_INIT = 3'd0,
        PB_HOLD  = 3'd1,
        WAIT_UP  = 3'd2,
        QUALIFY  = 3'd3,
        LINK_UP  = 3'd4
    } state_t;

    // Terminal timer values: a state lasting N cycles exits when the timer shows N-1.
    localparam logic [CntWidth-1:0] PmaLast     = CntWidth'(PmaInitCycles - 1);
    localparam logic [CntWidth-1:0] PbLast      = CntWidth'(ResetPbCycles - 1);
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(LinkTimeoutCycles - 1);
    localparam logic [CntWidth-1:0] StableLast  = CntWidth'(StableCycles - 1);
    localparam logic [7:0]          SoftMax     = 8'(MaxSoftRetries);

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       stable_s;

    state_t              state_q;
    state_t              state_d;
    logic [CntWidth-1:0] timer_q;
    logic [7:0]          soft_q;
    logic                do_retry;
    logic                retry_evt;
    logic                soft_inc;
    logic                soft_clr;
    logic                timer_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= {aurora_gt_pll_lock, aurora_channel_up, aurora_lane_up};
            sync2_q <= sync1_q;
        end
    end

    assign stable_s = &sync2_q;

    always_comb begin
        state_d   = state_q;
        do_retry  = 1'b0;
        retry_evt = 1'b0;
        soft_inc  = 1'b0;
        soft_clr  = 1'b0;
        if (relink_req) begin
            state_d   = PMA_INIT;
            retry_evt = 1'b1;
        end else begin
            case (state_q)
                PMA_INIT: begin
                    if (timer_q == PmaLast) begin
                        state_d  = PB_HOLD;
                        soft_clr = 1'b1;
                    end
                end
                PB_HOLD: begin
                    if (timer_q == PbLast) state_d = WAIT_UP;
                end
                WAIT_UP: begin
                    // Stable beats a coincident timeout.
                    if (stable_s) state_d = QUALIFY;
                    else if (timer_q == TimeoutLast) do_retry = 1'b1;
                end
                QUALIFY: begin
                    // A drop beats a coincident qualify expiry.
                    if (!stable_s) begin
                        state_d = WAIT_UP;
                    end else if (timer_q == StableLast) begin
                        state_d  = LINK_UP;
                        soft_clr = 1'b1;
                    end
                end
                LINK_UP: begin
                    if (!stable_s) do_retry = 1'b1;
                end
                default: state_d = PMA_INIT;
            endcase
            if (do_retry) begin
                retry_evt = 1'b1;
                if (soft_q < SoftMax) begin
                    soft_inc = 1'b1;
                    state_d  = PB_HOLD;
                end else begin
                    state_d = PMA_INIT;
                end
            end
        end
    end

    // relink_req inside PMA_INIT keeps the state but must still restart the timer.
    assign timer_clr = (state_d != state_q) || relink_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= PMA_INIT;
            timer_q         <= '0;
            soft_q          <= 8'd0;
            retry_count     <= 8'd0;
            aurora_pma_init <= 1'b1;
            aurora_reset_pb <= 1'b1;
            peri_reset      <= 1'b1;
            link_ok         <= 1'b0;
        end else begin
            state_q <= state_d;
            if (timer_clr) timer_q <= '0;
            else if (timer_q != '1) timer_q <= timer_q + 1'b1;
            if (soft_clr) soft_q <= 8'd0;
            else if (soft_inc) soft_q <= soft_q + 8'd1;
            if (retry_evt && retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
            aurora_pma_init <= (state_d == PMA_INIT);
            aurora_reset_pb <= (state_d == PMA_INIT) || (state_d == PB_HOLD);
            peri_reset      <= (state_d != LINK_UP);
            link_ok         <= (state_d == LINK_UP);
        end
    end

    assign link_state = state_q;

endmodule
